// File: rtl/toggle_handshake_receiver.sv
// toggle_handshake_receiver
// Receiving side of a two-phase (toggle) request/acknowledge handshake.
// Each phase change on req_toggle becomes one valid/ready transfer of
// req_data; ack_toggle flips back once the downstream consumer accepts it.
// Requests that arrive while a word is still pending are dropped and
// recorded in a sticky overrun flag plus a saturating event counter.
// Every output is driven straight from a flop; no input reaches an output
// combinationally.

module toggle_handshake_receiver #(
    parameter int   WORD_WIDTH      = 0,
    parameter logic REQ_RESET_VALUE = 1'b0,
    parameter int   COUNT_WIDTH     = 8,
    // Guards the port range against the unset default of WORD_WIDTH.
    localparam int  W               = (WORD_WIDTH < 1) ? 1 : WORD_WIDTH
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   clear,
    input  logic                   req_toggle,
    input  logic [W-1:0]           req_data,
    output logic                   ack_toggle,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [W-1:0]           out_data,
    output logic                   overrun,
    output logic [COUNT_WIDTH-1:0] overrun_count
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    localparam logic [COUNT_WIDTH-1:0] CNT_MAX = {COUNT_WIDTH{1'b1}};

    state_t                 r_state;
    logic                   r_req_seen;
    logic                   r_ack;
    logic                   r_overrun;
    logic [W-1:0]           r_data;
    logic [COUNT_WIDTH-1:0] r_count;
    logic                   w_event;

    // Saturating increment: the counter sticks at all-ones.
    function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
        logic [COUNT_WIDTH-1:0] res;
        if (v == CNT_MAX) begin
            res = v;
        end else begin
            res = v + COUNT_WIDTH'(1);
        end
        return res;
    endfunction

    // A request is any difference between the sender phase and the last accepted phase.
    assign w_event = req_toggle ^ r_req_seen;

    // Handshake state machine: capture, hold under backpressure, acknowledge, and log overruns.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_req_seen <= REQ_RESET_VALUE;
            r_ack      <= REQ_RESET_VALUE;
            r_overrun  <= 1'b0;
            r_data     <= '0;
            r_count    <= '0;
        end else if (clear) begin
            // Drop any pending word and resynchronise both phases to the sender,
            // so the sender sees its request acknowledged and no event follows.
            r_state    <= S_IDLE;
            r_req_seen <= req_toggle;
            r_ack      <= req_toggle;
            r_overrun  <= 1'b0;
            r_data     <= '0;
            r_count    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_event) begin
                        r_data     <= req_data;
                        r_req_seen <= req_toggle;
                        r_state    <= S_HOLD;
                    end else begin
                        r_state    <= S_IDLE;
                    end
                end
                S_HOLD: begin
                    // Completion and a violating request may land on the same edge;
                    // both are applied independently.
                    if (out_ready) begin
                        r_ack   <= ~r_ack;
                        r_state <= S_IDLE;
                    end else begin
                        r_state <= S_HOLD;
                    end
                    if (w_event) begin
                        // The new request is dropped, not queued; out_data is kept.
                        r_req_seen <= req_toggle;
                        r_overrun  <= 1'b1;
                        r_count    <= sat_inc(r_count);
                    end else begin
                        r_req_seen <= r_req_seen;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign out_valid     = (r_state == S_HOLD);
    assign out_data      = r_data;
    assign ack_toggle    = r_ack;
    assign overrun       = r_overrun;
    assign overrun_count = r_count;

endmodule

// File: doc/toggle_handshake_receiver.md
# toggle_handshake_receiver

Receiving end of the two-phase (toggle) request/acknowledge handshake: a sender flips `req_toggle` (typically from a `register_toggle`) with `req_data` held stable, and this block converts each request phase change into a single valid/ready transfer, then flips `ack_toggle` back to the sender once the downstream consumer accepts the word. It sits between toggle-signalling producers (register blocks, command sources) and valid/ready pipelines in the same clock domain, and flags protocol violations (overruns) for debug.

## Interface

- `WORD_WIDTH`, default 0 (must be set ≥ 1): width of `req_data`/`out_data`.
- `REQ_RESET_VALUE`, default 0: phase of `req_toggle` at reset; also the reset value of `ack_toggle` and the internal last-seen phase.
- `COUNT_WIDTH`, default 8: width of the saturating overrun counter.

- `clock` input 1: single clock; all logic on rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `clear` input 1: synchronous clear, active high.
- `req_toggle` input 1: sender request phase; any change is one request.
- `req_data` input WORD_WIDTH: request payload, stable from the toggle until `ack_toggle` matches.
- `ack_toggle` output 1: acknowledge phase; flips once per completed transfer.
- `out_valid` output 1: downstream valid.
- `out_ready` input 1: downstream ready.
- `out_data` output WORD_WIDTH: captured payload.
- `overrun` output 1: sticky; set when a request arrives while a transfer is pending.
- `overrun_count` output COUNT_WIDTH: overrun events, saturating at all-ones.

## Operation

- Internal `req_seen` register holds the last accepted request phase; event = `req_toggle != req_seen`.
- State is `IDLE` (`out_valid`=0) or `HOLD` (`out_valid`=1); `out_valid` is the registered state bit.
- `IDLE`, event: `out_data <= req_data`, `req_seen <= req_toggle`, go `HOLD`.
- `IDLE`, no event: hold all.
- `HOLD`, `out_ready`=1: transfer completes; `ack_toggle <= ~ack_toggle`, go `IDLE`.
- `HOLD`, `out_ready`=0: hold `out_valid` and `out_data` stable (no change while valid and not ready).
- `HOLD`, event (protocol violation): `req_seen <= req_toggle` (request dropped, not queued), `overrun <= 1`, `overrun_count` increments unless all-ones; `out_data` unchanged. May coincide with completion; both take effect.
- Each phase change is counted once; a toggle-and-back over two cycles in `HOLD` counts 2.
- `clear` (priority over all except `reset_n`): `out_valid <= 0`, `out_data <= 0`, `overrun <= 0`, `overrun_count <= 0`, `req_seen <= req_toggle`, `ack_toggle <= req_toggle` (pending transfer dropped; sender sees it as acknowledged; no spurious event).
- Reset values: `out_valid`=0, `out_data`=0, `overrun`=0, `overrun_count`=0, `ack_toggle`=`req_seen`=`REQ_RESET_VALUE`, state `IDLE`. Reset mid-transfer drops the word immediately (asynchronous).

## Timing

- Request latency: `req_toggle` changes before edge N (sampled at N) → `out_valid`=1 and `out_data` valid after edge N.
- Acknowledge latency: `out_valid && out_ready` at edge M → `ack_toggle` flips and `out_valid` falls after edge M.
- Throughput: next request seen at edge M+1 at the earliest (sender reacting combinationally to `ack_toggle`); max one word per 2 cycles.
- `overrun`/`overrun_count` update one edge after the violating toggle is sampled.
- No combinational path from any input to any output.

## Test plan

- Reset with `REQ_RESET_VALUE`=1: all outputs at reset values, `ack_toggle`=1; hold `req_toggle`=1 10 cycles → `out_valid` stays 0.
- Single transfer, `out_ready`=1: toggle req 0→1 with data 0xA5 at edge 5 → `out_valid`=1, `out_data`=0xA5 after edge 5; valid falls and `ack_toggle` 0→1 after edge 6.
- Backpressure: `out_ready`=0 for 7 cycles after capture → `out_valid` and `out_data` stable, `ack_toggle` unchanged; ready high → ack flips exactly once.
- Back-to-back: sender toggles req the cycle after each ack flip, data 1,2,3,4 → four transfers in order, one every 2 cycles, `ack_toggle` ends equal to `req_toggle`, `overrun`=0.
- Overrun: in `HOLD`, toggle req twice more → `overrun`=1, `overrun_count`=2, `out_data` still first word; with COUNT_WIDTH=2, 5 violations → count saturates at 3.
- Clear and async reset mid-`HOLD`: `clear` → `out_valid`=0, counts 0, `ack_toggle`=`req_toggle`, no new transfer next cycle; drop `reset_n` mid-cycle → outputs reset before next edge.
